// File: rtl/alu_uart_interface.sv
// Command sequencer between a UART rx/tx pair and a combinational ALU.
// Collects A, B and opcode bytes, presents them stable to the ALU, and sends back the result.
module alu_uart_interface #(
  parameter int unsigned BITS_DATA = 8,
  parameter int unsigned BITS_OP   = 6
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_done,
  input  logic                 i_tx_done,
  input  logic [BITS_DATA-1:0] i_alu_result,
  output logic [BITS_DATA-1:0] o_alu_a,
  output logic [BITS_DATA-1:0] o_alu_b,
  output logic [BITS_OP-1:0]   o_alu_op,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_start,
  output logic                 o_busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_B  = 3'd1,
    S_WAIT_OP = 3'd2,
    S_EXEC    = 3'd3,
    S_SEND    = 3'd4,
    S_WAIT_TX = 3'd5
  } state_t;

  state_t state;

  // Received bytes only land in the register the current state expects; busy states drop them.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= S_IDLE;
      o_alu_a    <= '0;
      o_alu_b    <= '0;
      o_alu_op   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_rx_done) begin
            o_alu_a <= BITS_DATA'(i_rx_data);
            state   <= S_WAIT_B;
          end
        end
        S_WAIT_B: begin
          if (i_rx_done) begin
            o_alu_b <= BITS_DATA'(i_rx_data);
            state   <= S_WAIT_OP;
          end
        end
        S_WAIT_OP: begin
          if (i_rx_done) begin
            o_alu_op <= i_rx_data[BITS_OP-1:0];
            o_busy   <= 1'b1;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          o_tx_data  <= 8'(i_alu_result);
          o_tx_start <= 1'b1;
          state      <= S_SEND;
        end
        S_SEND: begin
          o_tx_start <= 1'b0;
          state      <= S_WAIT_TX;
        end
        S_WAIT_TX: begin
          // A byte arriving with tx_done is dropped, not taken as the next operand A.
          if (i_tx_done) begin
            o_busy <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: begin
          o_tx_start <= 1'b0;
          o_busy     <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_uart_interface.sv
// Randomized self-checking bench for alu_uart_interface with a behavioural ALU and result model.
module tb_alu_uart_interface;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [7:0] i_rx_data;
  logic       i_rx_done;
  logic       i_tx_done;
  logic [7:0] i_alu_result;
  logic [7:0] o_alu_a;
  logic [7:0] o_alu_b;
  logic [5:0] o_alu_op;
  logic [7:0] o_tx_data;
  logic       o_tx_start;
  logic       o_busy;

  int vectors     = 0;
  int miscompares = 0;
  int start_cnt   = 0;

  alu_uart_interface #(.BITS_DATA(8), .BITS_OP(6)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_rx_data    (i_rx_data),
    .i_rx_done    (i_rx_done),
    .i_tx_done    (i_tx_done),
    .i_alu_result (i_alu_result),
    .o_alu_a      (o_alu_a),
    .o_alu_b      (o_alu_b),
    .o_alu_op     (o_alu_op),
    .o_tx_data    (o_tx_data),
    .o_tx_start   (o_tx_start),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20: return 8'(a + b);
      6'h22: return 8'(a - b);
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h03: return 8'($signed(a) >>> b);
      6'h02: return a >> b;
      default: return 8'h00;
    endcase
  endfunction

  // Stand-in for the combinational ALU fed by the DUT's registered operands.
  assign i_alu_result = alu_ref(o_alu_a, o_alu_b, o_alu_op);

  always @(negedge i_clk) if (o_tx_start) start_cnt++;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    tick();
    i_rx_done = 1'b0;
  endtask

  task automatic tx_pulse();
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
  endtask

  // One full command; expected result comes from the bytes sent, not from DUT outputs.
  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                         input int gap, input int txd, input bit inject, input bit stray_tx);
    logic [7:0] exp;
    int sc;
    exp = alu_ref(a, b, opb[5:0]);
    if (stray_tx) begin
      tx_pulse();
      check("busy_idle_txdone", 8'(o_busy), 8'h00);
    end
    rx_byte(a);
    check("alu_a", o_alu_a, a);
    if (stray_tx) tx_pulse();
    repeat (gap) tick();
    rx_byte(b);
    check("alu_b", o_alu_b, b);
    repeat (gap) tick();
    sc = start_cnt;
    rx_byte(opb);
    check("alu_op", 8'(o_alu_op), {2'b00, opb[5:0]});
    check("busy_exec", 8'(o_busy), 8'h01);
    check("start_k", 8'(o_tx_start), 8'h00);
    if (inject) begin
      i_rx_data = ~a;
      i_rx_done = 1'b1;
    end
    tick();
    i_rx_done = 1'b0;
    check("start_k1", 8'(o_tx_start), 8'h01);
    check("tx_data", o_tx_data, exp);
    tick();
    check("start_k2", 8'(o_tx_start), 8'h00);
    check("busy_wait", 8'(o_busy), 8'h01);
    if (inject) rx_byte(8'h5A);
    repeat (txd) tick();
    if (inject) begin
      i_rx_data = 8'hAA;
      i_rx_done = 1'b1;
    end
    tx_pulse();
    i_rx_done = 1'b0;
    check("busy_done", 8'(o_busy), 8'h00);
    check("start_count", 8'(start_cnt - sc), 8'h01);
    check("a_held", o_alu_a, a);
    check("b_held", o_alu_b, b);
  endtask

  logic [7:0] ops [10] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02, 8'h3F, 8'hA0};

  initial begin
    i_reset   = 1'b1;
    i_rx_data = 8'h00;
    i_rx_done = 1'b0;
    i_tx_done = 1'b0;
    tick();
    tick();
    check("rst_a", o_alu_a, 8'h00);
    check("rst_op", 8'(o_alu_op), 8'h00);
    check("rst_busy", 8'(o_busy), 8'h00);
    i_reset = 1'b0;
    tick();

    run_cmd(8'h05, 8'h03, 8'h20, 1, 3, 1'b0, 1'b0);
    run_cmd(8'h03, 8'h05, 8'h22, 0, 0, 1'b0, 1'b0);
    run_cmd(8'h80, 8'h02, 8'h03, 2, 1, 1'b0, 1'b0);
    run_cmd(8'h80, 8'h02, 8'h02, 0, 2, 1'b0, 1'b0);
    run_cmd(8'h0F, 8'hF0, 8'hA0, 1, 1, 1'b0, 1'b0);
    run_cmd(8'h12, 8'h34, 8'h3F, 0, 1, 1'b0, 1'b0);
    run_cmd(8'h11, 8'h22, 8'h20, 0, 2, 1'b1, 1'b0);
    run_cmd(8'h01, 8'h01, 8'h20, 0, 0, 1'b0, 1'b0);
    run_cmd(8'h44, 8'h0C, 8'h25, 1, 1, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a partial command.
    rx_byte(8'h07);
    rx_byte(8'h09);
    #3 i_reset = 1'b1;
    #1;
    check("arst_a", o_alu_a, 8'h00);
    check("arst_b", o_alu_b, 8'h00);
    check("arst_op", 8'(o_alu_op), 8'h00);
    check("arst_tx", o_tx_data, 8'h00);
    check("arst_start", 8'(o_tx_start), 8'h00);
    check("arst_busy", 8'(o_busy), 8'h00);
    tick();
    i_reset = 1'b0;
    tick();
    run_cmd(8'h02, 8'h02, 8'h24, 0, 1, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      run_cmd(8'($urandom), 8'($urandom), ops[$urandom_range(0, 9)],
              int'($urandom_range(0, 2)), int'($urandom_range(0, 5)),
              1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
